// File: rtl/write_arbiter_rr_pkg.sv
// Shared types and helpers for the render-core write arbiter.
// Holds the FSM state encoding, the arbitration mode constants and the address-word builder.
package write_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_ADDR = 2'd1,
    SEND_DATA = 2'd2,
    DONE      = 2'd3
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Widest FIFO word the builder supports; callers truncate to their own DATA_W.
  localparam int WORD_MAX_W = 128;
  typedef logic [WORD_MAX_W-1:0] word_max_t;

  // Address word: optional core tag in the top idx_w bits, zero pad, then addr[addr_w-1:0].
  function automatic word_max_t build_addr_word(
    input word_max_t addr,
    input word_max_t idx,
    input int        addr_w,
    input int        idx_w,
    input int        data_w,
    input bit        tag_en
  );
    word_max_t addr_mask;
    word_max_t tag_part;
    addr_mask = (word_max_t'(1) << addr_w) - word_max_t'(1);
    tag_part  = tag_en ? (idx << (data_w - idx_w)) : '0;
    return (addr & addr_mask) | tag_part;
  endfunction

endpackage

// File: rtl/write_arbiter_rr_if.sv
// Core-array and write-FIFO signal bundle for write_arbiter_rr.
// The arbiter takes the master view; the core array / FIFO side takes the slave view.
interface write_arbiter_rr_if #(
  parameter int NUM_CORES = 87,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = $clog2(NUM_CORES)
);
  logic [NUM_CORES-1:0]             write_req;
  logic [NUM_CORES-1:0][31:0]       write_addr;
  logic [NUM_CORES-1:0][DATA_W-1:0] write_data;
  logic [NUM_CORES-1:0]             write_valid;
  logic [NUM_CORES-1:0]             write_done;
  logic                             FF_writerequest;
  logic                             FF_almostfull;
  logic [DATA_W-1:0]                FF_data;
  logic                             busy;
  logic [IDX_W-1:0]                 grant_idx;

  modport master (
    input  write_req, write_addr, write_data, FF_almostfull,
    output write_valid, write_done, FF_writerequest, FF_data, busy, grant_idx
  );

  modport slave (
    output write_req, write_addr, write_data, FF_almostfull,
    input  write_valid, write_done, FF_writerequest, FF_data, busy, grant_idx
  );
endinterface

// File: rtl/write_arbiter_rr_arbiter.sv
// Combinational winner selection: round-robin from ptr (wrapping) or fixed lowest-index priority.
// Round-robin uses a masked priority encoder that falls back to the unmasked one.
module rr_arbiter
  import write_arb_pkg::*;
#(
  parameter int NUM_CORES = 87,
  parameter int ARB_MODE  = ARB_RR,
  localparam int IDX_W    = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     grant,
  output logic                 found
);

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CORES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign found = |req;

  if (ARB_MODE == ARB_RR) begin : g_rr
    logic [NUM_CORES-1:0] upper_mask;
    logic [NUM_CORES-1:0] masked_req;

    always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
        upper_mask[i] = (IDX_W'(i) >= ptr);
      end
    end

    // Requests at or above ptr win first; if none, wrap to the lowest requester overall.
    assign masked_req = req & upper_mask;
    assign grant      = (|masked_req) ? lowest_set(masked_req) : lowest_set(req);
  end else begin : g_fixed
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign grant      = lowest_set(req);
  end

endmodule

// File: rtl/write_arbiter_rr.sv
// Render-core write arbiter: picks one requesting core, pushes its address word then its
// data word into the shared write FIFO, and returns a one-cycle write_done to that core.
module write_arbiter_rr
  import write_arb_pkg::*;
#(
  parameter int NUM_CORES = 87,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = $clog2(NUM_CORES),
  parameter int ARB_MODE  = ARB_RR,
  parameter int TAG_EN    = 0
) (
  input logic               clk,
  input logic               rst_n,
  write_arbiter_rr_if.master bus
);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [IDX_W-1:0]  arb_idx;
  logic              arb_found;

  // Only addr[ADDR_W-1:0] is forwarded; the remaining address bits are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.write_addr;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .req   (bus.write_req),
    .ptr   (ptr_q),
    .grant (arb_idx),
    .found (arb_found)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            grant_q <= arb_idx;
            addr_q  <= bus.write_addr[arb_idx][ADDR_W-1:0];
            data_q  <= bus.write_data[arb_idx];
            state_q <= SEND_ADDR;
          end
        end
        SEND_ADDR: if (!bus.FF_almostfull) state_q <= SEND_DATA;
        SEND_DATA: if (!bus.FF_almostfull) state_q <= DONE;
        DONE: begin
          ptr_q   <= (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + IDX_W'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [NUM_CORES-1:0] valid_c;
  logic [NUM_CORES-1:0] done_c;
  logic                 push_c;
  logic [DATA_W-1:0]    ff_data_c;

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    valid_c   = '0;
    done_c    = '0;
    push_c    = 1'b0;
    ff_data_c = '0;
    case (state_q)
      SEND_ADDR: begin
        if (!bus.FF_almostfull) begin
          push_c           = 1'b1;
          valid_c[grant_q] = 1'b1;
          ff_data_c        = DATA_W'(build_addr_word(word_max_t'(addr_q), word_max_t'(grant_q),
                                                     ADDR_W, IDX_W, DATA_W, TAG_EN != 0));
        end
      end
      SEND_DATA: begin
        if (!bus.FF_almostfull) begin
          push_c           = 1'b1;
          valid_c[grant_q] = 1'b1;
          ff_data_c        = data_q;
        end
      end
      DONE:    done_c[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign bus.write_valid     = valid_c;
  assign bus.write_done      = done_c;
  assign bus.FF_writerequest = push_c;
  assign bus.FF_data         = ff_data_c;
  assign bus.busy            = (state_q != IDLE);
  assign bus.grant_idx       = (state_q == IDLE) ? '0 : grant_q;

endmodule

// File: tb/tb_write_arbiter_rr.sv
// Directed bench for write_arbiter_rr: a round-robin untagged instance and a fixed-priority
// tagged instance, both with 87 cores, checked against hand-computed FIFO words and pulses.
module tb_write_arbiter_rr;
  localparam int NC = 87;
  localparam int DW = 32;
  localparam int IW = 7;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  write_arbiter_rr_if #(.NUM_CORES(NC), .DATA_W(DW), .IDX_W(IW)) if_rr ();
  write_arbiter_rr_if #(.NUM_CORES(NC), .DATA_W(DW), .IDX_W(IW)) if_fx ();

  write_arbiter_rr #(
    .NUM_CORES(NC), .ADDR_W(23), .DATA_W(DW), .IDX_W(IW), .ARB_MODE(1), .TAG_EN(0)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(if_rr.master)
  );

  write_arbiter_rr #(
    .NUM_CORES(NC), .ADDR_W(23), .DATA_W(DW), .IDX_W(IW), .ARB_MODE(0), .TAG_EN(1)
  ) dut_fx (
    .clk(clk), .rst_n(rst_n), .bus(if_fx.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic          s_wreq;
  logic [DW-1:0] s_data;
  logic [NC-1:0] s_valid;
  logic [NC-1:0] s_done;
  logic          s_busy;
  logic [IW-1:0] s_grant;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit sel);
    if (sel) begin
      s_wreq = if_fx.FF_writerequest; s_data = if_fx.FF_data; s_valid = if_fx.write_valid;
      s_done = if_fx.write_done;      s_busy = if_fx.busy;    s_grant = if_fx.grant_idx;
    end else begin
      s_wreq = if_rr.FF_writerequest; s_data = if_rr.FF_data; s_valid = if_rr.write_valid;
      s_done = if_rr.write_done;      s_busy = if_rr.busy;    s_grant = if_rr.grant_idx;
    end
  endtask

  task automatic set_req(input bit sel, input int idx, input logic v);
    if (sel) if_fx.write_req[idx] = v;
    else     if_rr.write_req[idx] = v;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_push"},  128'(s_wreq),  128'(0));
    check({tag, "_data"},  128'(s_data),  128'(0));
    check({tag, "_valid"}, 128'(s_valid), 128'(0));
    check({tag, "_done"},  128'(s_done),  128'(0));
  endtask

  // Called at a negedge while the DUT is IDLE with req[idx] winning; ends at the next IDLE negedge.
  task automatic txn(input bit sel, input int idx, input logic [31:0] aw, input logic [31:0] dw);
    logic [NC-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    @(negedge clk); #1; sample(sel);
    check("addr_push",  128'(s_wreq),  128'(1));
    check("addr_word",  128'(s_data),  128'(aw));
    check("addr_valid", 128'(s_valid), 128'(oh));
    check("grant_idx",  128'(s_grant), 128'(idx));
    @(negedge clk); #1; sample(sel);
    check("data_push",  128'(s_wreq),  128'(1));
    check("data_word",  128'(s_data),  128'(dw));
    check("data_valid", 128'(s_valid), 128'(oh));
    @(negedge clk); set_req(sel, idx, 1'b0); #1; sample(sel);
    check("done_pulse", 128'(s_done),  128'(oh));
    check("done_nopush", 128'(s_wreq), 128'(0));
    check("done_data",  128'(s_data),  128'(0));
    @(negedge clk); #1; sample(sel);
    check("idle_busy",  128'(s_busy),  128'(0));
    check("idle_done",  128'(s_done),  128'(0));
    check("idle_grant", 128'(s_grant), 128'(0));
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; #1;
    sample(0); check_quiet("rst_rr");
    check("rst_rr_busy",  128'(s_busy),  128'(0));
    check("rst_rr_grant", 128'(s_grant), 128'(0));
    sample(1); check_quiet("rst_fx");
    check("rst_fx_busy",  128'(s_busy),  128'(0));
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    int push_cnt;
    int cyc;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    if_rr.write_req = '0; if_rr.FF_almostfull = 1'b0;
    if_fx.write_req = '0; if_fx.FF_almostfull = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if_rr.write_addr[i] = 32'hABC0_0000 + 32'(i);
      if_rr.write_data[i] = 32'h5000_0000 + 32'(i);
      if_fx.write_addr[i] = 32'hABC0_0000 + 32'(i);
      if_fx.write_data[i] = 32'h5000_0000 + 32'(i);
    end
    do_reset();

    // Single request from core 5; addr/data/req change after grant must not matter.
    if_rr.write_addr[5] = 32'h0012_3456;
    if_rr.write_data[5] = 32'hDEAD_BEEF;
    if_rr.write_req[5]  = 1'b1;
    #1; sample(0);
    check("t1_pre_busy", 128'(s_busy), 128'(0));
    @(negedge clk);
    if_rr.write_addr[5] = 32'h0; if_rr.write_data[5] = 32'h0; if_rr.write_req[5] = 1'b0;
    #1; sample(0);
    check("t1_addr_word",  128'(s_data),  128'(32'h0012_3456));
    check("t1_addr_valid", 128'(s_valid), 128'(1) << 5);
    check("t1_grant",      128'(s_grant), 128'(5));
    @(negedge clk); #1; sample(0);
    check("t1_data_word",  128'(s_data),  128'(32'hDEAD_BEEF));
    check("t1_data_valid", 128'(s_valid), 128'(1) << 5);
    @(negedge clk); #1; sample(0);
    check("t1_done",       128'(s_done),  128'(1) << 5);
    check("t1_done_valid", 128'(s_valid), 128'(0));
    @(negedge clk); #1; sample(0);
    check("t1_idle_busy",  128'(s_busy),  128'(0));

    // Round-robin from ptr=0: 2, 40, 86, then wrap lets 2 beat 10, then 40 beats 2.
    do_reset();
    if_rr.write_req[2] = 1'b1; if_rr.write_req[40] = 1'b1; if_rr.write_req[86] = 1'b1;
    txn(0, 2,  32'h0040_0002, 32'h5000_0002);
    txn(0, 40, 32'h0040_0028, 32'h5000_0028);
    txn(0, 86, 32'h0040_0056, 32'h5000_0056);
    if_rr.write_req[10] = 1'b1; if_rr.write_req[2] = 1'b1;
    txn(0, 2,  32'h0040_0002, 32'h5000_0002);
    txn(0, 10, 32'h0040_000A, 32'h5000_000A);
    if_rr.write_req[40] = 1'b1; if_rr.write_req[2] = 1'b1;
    txn(0, 40, 32'h0040_0028, 32'h5000_0028);
    txn(0, 2,  32'h0040_0002, 32'h5000_0002);

    // Back-pressure on core 7: 5 cycles in SEND_ADDR, 3 in SEND_DATA.
    push_cnt = 0;
    cyc = 0;
    if_rr.write_req[7] = 1'b1;
    if_rr.FF_almostfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cyc++; #1; sample(0);
      push_cnt += int'(s_wreq);
      check("bp_addr_hold_push", 128'(s_wreq), 128'(0));
      check("bp_addr_hold_busy", 128'(s_busy), 128'(1));
    end
    @(negedge clk); cyc++; if_rr.FF_almostfull = 1'b0; #1; sample(0);
    push_cnt += int'(s_wreq);
    check("bp_addr_word", 128'(s_data), 128'(32'h0040_0007));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cyc++; if_rr.FF_almostfull = 1'b1; #1; sample(0);
      push_cnt += int'(s_wreq);
      check("bp_data_hold_push", 128'(s_wreq), 128'(0));
      check("bp_data_hold_data", 128'(s_data), 128'(0));
    end
    @(negedge clk); cyc++; if_rr.FF_almostfull = 1'b0; #1; sample(0);
    push_cnt += int'(s_wreq);
    check("bp_data_word", 128'(s_data), 128'(32'h5000_0007));
    @(negedge clk); cyc++; if_rr.write_req[7] = 1'b0; #1; sample(0);
    push_cnt += int'(s_wreq);
    check("bp_done",       128'(s_done), 128'(1) << 7);
    check("bp_done_cycle", 128'(cyc),    128'(11));
    @(negedge clk); #1; sample(0);
    push_cnt += int'(s_wreq);
    check("bp_push_count", 128'(push_cnt), 128'(2));

    // Fixed priority with tag: 1 before 3; then 2 before 86 regardless of ptr.
    if_fx.write_req[3] = 1'b1; if_fx.write_req[1] = 1'b1;
    txn(1, 1, 32'h0240_0001, 32'h5000_0001);
    txn(1, 3, 32'h0640_0003, 32'h5000_0003);
    if_fx.write_req[86] = 1'b1; if_fx.write_req[2] = 1'b1;
    txn(1, 2,  32'h0440_0002, 32'h5000_0002);
    if_fx.write_addr[86] = 32'h007F_FFFF;
    txn(1, 86, 32'hAC7F_FFFF, 32'h5000_0056);

    // Reset in SEND_DATA: ptr is 8, so core 9 wins first; after reset core 1 must win.
    if_rr.write_req[9] = 1'b1; if_rr.write_req[1] = 1'b1;
    @(negedge clk); #1; sample(0);
    check("rst_mid_grant", 128'(s_grant), 128'(9));
    @(negedge clk); #1; sample(0);
    check("rst_mid_data", 128'(s_data), 128'(32'h5000_0009));
    rst_n = 1'b0; #1; sample(0);
    check_quiet("rst_mid_now");
    check("rst_mid_busy", 128'(s_busy), 128'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1; sample(0);
      check("rst_mid_nodone", 128'(s_done), 128'(0));
    end
    @(negedge clk); rst_n = 1'b1;
    txn(0, 1, 32'h0040_0001, 32'h5000_0001);
    txn(0, 9, 32'h0040_0009, 32'h5000_0009);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
